// File: rtl/pll_lock_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL lock / reset sequencer: state encoding,
// saturating status-counter increment and parameter legality check.
package pll_lock_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  // Increment that sticks at the all-ones value of a counter 'width' bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : (value + 32'd1);
  endfunction

  function automatic bit fits(input int unsigned cnt_width, input int unsigned cycles);
    return (cnt_width >= 32'd32) || (64'(cycles) <= (64'd1 << cnt_width));
  endfunction

  function automatic bit params_legal(input int unsigned cnt_width,
                                      input int unsigned rst_cycles,
                                      input int unsigned timeout_cycles,
                                      input int unsigned stable_cycles);
    return (cnt_width >= 32'd1) && (rst_cycles >= 32'd2) &&
           (timeout_cycles >= 32'd1) && (stable_cycles >= 32'd1) &&
           fits(cnt_width, rst_cycles) && fits(cnt_width, timeout_cycles) &&
           fits(cnt_width, stable_cycles);
  endfunction

endpackage

// File: rtl/pll_lock_reset_sequencer_lock_sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs; clears to 0 on reset.
module lock_sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Sequences the PLL reset pulse, debounces lock, retries on lock timeout and
// releases a registered active-low reset once lock has been stable long enough.
module pll_lock_reset_sequencer
  import pll_lock_reset_sequencer_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_WIDTH           = 17,
  parameter int unsigned STAT_WIDTH          = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  PLL_LOCKED_IN,
  output logic                  PLL_RST_OUT,
  output logic                  RST_N_OUT,
  output logic                  READY_OUT,
  output logic [STAT_WIDTH-1:0] LOSS_COUNT_OUT,
  output logic [STAT_WIDTH-1:0] TIMEOUT_COUNT_OUT
);

  if (!params_legal(CNT_WIDTH, PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) begin : g_param_error
    $error("pll_lock_reset_sequencer: illegal parameter set");
  end

  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(PLL_RST_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1'b1);

  logic                  lock_s;
  seq_state_e            state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  pll_rst_q;
  logic                  rst_n_out_q;
  logic                  ready_q;
  logic [STAT_WIDTH-1:0] loss_q;
  logic [STAT_WIDTH-1:0] timeout_q;

  lock_sync_2ff u_lock_sync (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .async_i (PLL_LOCKED_IN),
    .sync_o  (lock_s)
  );

  // Every output transition is decided on the same edge as the state change,
  // so RST_N_OUT can never be high while PLL_RST_OUT is high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_n_out_q <= 1'b0;
      ready_q     <= 1'b0;
      loss_q      <= '0;
      timeout_q   <= '0;
    end else begin
      case (state_q)
        ST_PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q + CNT_ONE;
            pll_rst_q <= 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= ST_PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            timeout_q <= STAT_WIDTH'(sat_inc(32'(timeout_q), STAT_WIDTH));
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q     <= ST_RUN;
            rst_n_out_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            rst_n_out_q <= 1'b0;
            ready_q     <= 1'b0;
            loss_q      <= STAT_WIDTH'(sat_inc(32'(loss_q), STAT_WIDTH));
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q     <= ST_PLL_RESET;
          cnt_q       <= '0;
          pll_rst_q   <= 1'b1;
          rst_n_out_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign PLL_RST_OUT       = pll_rst_q;
  assign RST_N_OUT         = rst_n_out_q;
  assign READY_OUT         = ready_q;
  assign LOSS_COUNT_OUT    = loss_q;
  assign TIMEOUT_COUNT_OUT = timeout_q;

endmodule
